// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - byte-wide RAM with a streaming load sequencer and combinational read port
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start, base, len    load request (IDLE only): first address and byte count
//   abort               cancels a load in progress (no done pulse)
//   in_valid, in_data   byte stream into the RAM
//   in_ready            loader accepts a byte this cycle
//   busy                high in LOAD and DONE
//   done                one-cycle pulse when a load completes normally
//   count               bytes written by the current or last load
//   Dir, Dato_s         combinational read port, Dato_s = mem[Dir]

module ram_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  count,
    input  logic [ADDR_W-1:0] Dir,
    output logic [DATA_W-1:0] Dato_s
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [LEN_W-1:0]  remaining, remaining_nxt;
    logic [LEN_W-1:0]  count_nxt;
    logic              xfer;

    // Storage is deliberately not reset; contents are undefined until written.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // abort blocks acceptance in the same cycle so an aborting cycle never writes.
    assign in_ready = (state == LOAD) && !abort;
    assign xfer     = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign Dato_s   = mem[Dir];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            count     <= '0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            remaining <= remaining_nxt;
            count     <= count_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        remaining_nxt = remaining;
        count_nxt     = count;
        case (state)
            IDLE: begin
                // start wins over abort here since abort only matters in LOAD.
                if (start) begin
                    count_nxt = '0;
                    if (len != '0) begin
                        state_nxt     = LOAD;
                        addr_nxt      = base;
                        remaining_nxt = len;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (xfer) begin
                    // addr wraps naturally at the top of the RAM.
                    addr_nxt      = addr + 1'b1;
                    remaining_nxt = remaining - 1'b1;
                    count_nxt     = count + 1'b1;
                    if (remaining == LEN_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[addr] <= in_data;
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - directed self-checking bench for ram_loader

module tb_ram_loader;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] base;
    logic [8:0] len;
    logic       abort;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [8:0] count;
    logic [7:0] Dir;
    logic [7:0] Dato_s;

    int total;
    int bad;
    int done_seen;
    logic [7:0] buf_q [0:15];
    logic [7:0] s1 [0:11];

    ram_loader #(.ADDR_W(8), .DATA_W(8), .LEN_W(9)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base),
        .len      (len),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .Dir      (Dir),
        .Dato_s   (Dato_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int a);
        logic [7:0] v;
        v = 8'(a);
        return v ^ 8'h5A;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input int a, input logic [7:0] exp);
        Dir = 8'(a);
        #1;
        chk(tag, {24'd0, Dato_s}, {24'd0, exp});
    endtask

    task automatic do_start(input int b, input int l);
        start = 1'b1;
        base  = 8'(b);
        len   = 9'(l);
        tick();
        start = 1'b0;
    endtask

    // Feeds n bytes from buf_q (or the pat() sequence when use_pat); with stall,
    // each byte is followed by two idle cycles carrying junk data.
    task automatic feed(input int n, input bit stall, input bit use_pat);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = use_pat ? pat(i) : buf_q[i];
            #1;
            if (!use_pat) chk("rdy", {31'd0, in_ready}, 32'd1);
            tick();
            if (stall && i < n - 1) begin
                in_valid = 1'b0;
                in_data  = 8'hEE;
                tick();
                chk("gap_cnt", {23'd0, count}, 32'(i + 1));
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; done_seen = 0;
        rst = 1'b1; start = 1'b0; base = '0; len = '0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; Dir = '0;
        s1[0] = 8'd90;  s1[1] = 8'd80;  s1[2]  = 8'd40;  s1[3]  = 8'd60;
        s1[4] = 8'd50;  s1[5] = 8'd40;  s1[6]  = 8'd30;  s1[7]  = 8'd20;
        s1[8] = 8'd10;  s1[9] = 8'd100; s1[10] = 8'd101; s1[11] = 8'd102;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd0);
        chk("rst_cnt", {23'd0, count}, 32'd0);
        rst = 1'b0;
        tick();

        // Scenario 1: plain 12-byte load from address 0.
        for (int i = 0; i < 12; i++) buf_q[i] = s1[i];
        do_start(0, 12);
        chk("s1_busy", {31'd0, busy}, 32'd1);
        feed(12, 1'b0, 1'b0);
        chk("s1_done", {31'd0, done}, 32'd1);
        chk("s1_cnt", {23'd0, count}, 32'd12);
        tick();
        chk("s1_done_off", {31'd0, done}, 32'd0);
        chk("s1_idle", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 12; i++) rd("s1_mem", i, s1[i]);

        // Full-RAM load overwrites everything with a known pattern.
        do_start(0, 256);
        feed(256, 1'b0, 1'b1);
        chk("full_done", {31'd0, done}, 32'd1);
        chk("full_cnt", {23'd0, count}, 32'd256);
        tick();
        rd("full_m0", 0, pat(0));
        rd("full_m128", 128, pat(128));
        rd("full_m255", 255, pat(255));

        // Scenario 2: same 12 bytes with in_valid 1,0,0,1,...
        do_start(0, 12);
        feed(12, 1'b1, 1'b0);
        chk("s2_done", {31'd0, done}, 32'd1);
        chk("s2_cnt", {23'd0, count}, 32'd12);
        tick();
        for (int i = 0; i < 12; i++) rd("s2_mem", i, s1[i]);
        rd("s2_m12", 12, pat(12));

        // Scenario 3: wrap from 254, plus read-during-write on Dir=254.
        done_seen = 0;
        do_start(254, 4);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        rd("rdw_old", 254, pat(254));
        tick();
        rd("rdw_new", 254, 8'hAA);
        buf_q[0] = 8'hBB; buf_q[1] = 8'hCC; buf_q[2] = 8'hDD;
        feed(3, 1'b0, 1'b0);
        tick();
        tick();
        chk("wrap_pulses", 32'(done_seen), 32'd1);
        rd("wrap_254", 254, 8'hAA);
        rd("wrap_255", 255, 8'hBB);
        rd("wrap_0", 0, 8'hCC);
        rd("wrap_1", 1, 8'hDD);
        rd("wrap_2", 2, s1[2]);

        // Scenario 4: zero-length load.
        done_seen = 0;
        do_start(5, 0);
        chk("z_done", {31'd0, done}, 32'd1);
        chk("z_cnt", {23'd0, count}, 32'd0);
        tick();
        chk("z_done_off", {31'd0, done}, 32'd0);
        chk("z_pulses", 32'(done_seen), 32'd1);
        rd("z_m5", 5, s1[5]);

        // Scenario 5: abort after 3 of 8; a start during the load is ignored.
        done_seen = 0;
        buf_q[0] = 8'hE0; buf_q[1] = 8'hE1; buf_q[2] = 8'hE2;
        do_start(100, 8);
        feed(3, 1'b0, 1'b0);
        do_start(50, 2);
        chk("ab_busy", {31'd0, busy}, 32'd1);
        chk("ab_cnt_hold", {23'd0, count}, 32'd3);
        abort = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hFF;
        #1;
        chk("ab_rdy", {31'd0, in_ready}, 32'd0);
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("ab_idle", {31'd0, busy}, 32'd0);
        chk("ab_cnt", {23'd0, count}, 32'd3);
        tick();
        chk("ab_nodone", 32'(done_seen), 32'd0);
        rd("ab_m100", 100, 8'hE0);
        rd("ab_m102", 102, 8'hE2);
        rd("ab_m103", 103, pat(103));
        rd("ab_m50", 50, pat(50));
        buf_q[0] = 8'h77;
        do_start(200, 1);
        feed(1, 1'b0, 1'b0);
        chk("ab_restart_done", {31'd0, done}, 32'd1);
        chk("ab_restart_cnt", {23'd0, count}, 32'd1);
        tick();
        rd("ab_m200", 200, 8'h77);

        // Scenario 6: async reset after 5 of 10 bytes.
        for (int i = 0; i < 5; i++) buf_q[i] = 8'(8'h31 + i);
        do_start(150, 10);
        feed(5, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_done", {31'd0, done}, 32'd0);
        chk("ar_rdy", {31'd0, in_ready}, 32'd0);
        chk("ar_cnt", {23'd0, count}, 32'd0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) rd("ar_mem", 150 + i, 8'(8'h31 + i));
        rd("ar_m155", 155, pat(155));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
